// File: rtl/ball_motion_engine_pkg.sv
// ---------------------------------------------------------------------------
// ball_pkg
// Shared definitions for the ball motion engine:
//   - ball_state_e         : engine state (IDLE / MOVE / POP)
//   - screen/object geometry and the fixed-point scale
//   - MAX_SPEED            : speed limit, used only when BALL_SPEED_SAT_EN is defined
//   - bound_max()          : largest legal top-left coordinate, in subpixels
//   - clamp_pos()          : clamp a subpixel coordinate to [0, limit]
//   - sat_speed()          : clamp a speed to [-MAX_SPEED, +MAX_SPEED]
// ---------------------------------------------------------------------------
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    POP  = 2'd2
  } ball_state_e;

  // Must be a power of two; pixel coordinates are recovered by a shift.
  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FPM_SHIFT              = $clog2(FIXED_POINT_MULTIPLIER);

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int OBJECT_W  = 32;
  localparam int OBJECT_H  = 32;
  localparam int MAX_SPEED = 400;

  // Largest top-left coordinate (subpixels) that keeps the object on screen.
  function automatic int bound_max(input int pixels, input int object);
    return (pixels - object) * FIXED_POINT_MULTIPLIER;
  endfunction

  function automatic int clamp_pos(input int pos, input int limit);
    if (pos < 0) begin
      return 0;
    end else if (pos > limit) begin
      return limit;
    end
    return pos;
  endfunction

  function automatic int sat_speed(input int spd);
    if (spd > MAX_SPEED) begin
      return MAX_SPEED;
    end else if (spd < -MAX_SPEED) begin
      return -MAX_SPEED;
    end
    return spd;
  endfunction

endpackage

// File: rtl/ball_motion_engine_if.sv
// ---------------------------------------------------------------------------
// ball_motion_engine_if
// Bundles the split-stage request signals and the engine's results.
//   master : the split stage / draw logic side (drives requests, reads results)
//   slave  : the ball motion engine
// Requests : startOfFrame, spawn, spawnX, spawnY, Xspeed_in, Yspeed_in, kill
// Results  : spawn_ack, active, pop, topLeftX, topLeftY, Xspeed_out,
//            Yspeed_out, state_dbg (engine state, for observation only)
//
// Handshake: spawn is a level request sampled on each rising clock edge.
// It is accepted only when the engine is IDLE; acceptance is signalled by
// spawn_ack being high for exactly one cycle (the cycle after the sampling
// edge, together with active going high). A requester that sees no
// spawn_ack must assume the request was dropped; spawn is never queued.
// kill and startOfFrame are single-cycle pulses with no acknowledge.
// ---------------------------------------------------------------------------
interface ball_motion_engine_if;
  import ball_pkg::*;

  logic               startOfFrame;
  logic               spawn;
  logic signed [31:0] spawnX;
  logic signed [31:0] spawnY;
  logic signed [31:0] Xspeed_in;
  logic signed [31:0] Yspeed_in;
  logic               kill;

  logic               spawn_ack;
  logic               active;
  logic               pop;
  logic signed [31:0] topLeftX;
  logic signed [31:0] topLeftY;
  logic signed [31:0] Xspeed_out;
  logic signed [31:0] Yspeed_out;
  ball_state_e        state_dbg;

  modport master (
    output startOfFrame, spawn, spawnX, spawnY, Xspeed_in, Yspeed_in, kill,
    input  spawn_ack, active, pop, topLeftX, topLeftY, Xspeed_out, Yspeed_out,
           state_dbg
  );

  modport slave (
    input  startOfFrame, spawn, spawnX, spawnY, Xspeed_in, Yspeed_in, kill,
    output spawn_ack, active, pop, topLeftX, topLeftY, Xspeed_out, Yspeed_out,
           state_dbg
  );

endinterface

// File: rtl/ball_motion_engine_pop_frame_counter.sv
// ---------------------------------------------------------------------------
// pop_frame_counter
// Loadable down-counter that advances once per enabled frame tick.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : value loaded
//   en         : decrement enable (frame tick while popping)
//   done       : high in the cycle whose decrement takes the count to zero
// ---------------------------------------------------------------------------
module pop_frame_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // A count already at zero also reports done so a zero-length pop
  // still releases the engine on the next tick.
  assign done = en && !load && (count_q <= CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ball_motion_engine.sv
// ---------------------------------------------------------------------------
// ball_motion_engine
// One ball slot: loads a child ball from the split stage, integrates its
// fixed-point position once per frame with gravity and wall/floor/ceiling
// reflection, and runs a timed pop phase after a rope hit.
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : ball_motion_engine_if.slave (requests in, position/speed out)
// Optional build macro: BALL_SPEED_SAT_EN -- saturate speeds to
//   [-MAX_SPEED, +MAX_SPEED] after the reflection/gravity step and on spawn.
// ---------------------------------------------------------------------------
module ball_motion_engine
  import ball_pkg::*;
#(
  parameter int GRAVITY    = 4,
  parameter int POP_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  ball_motion_engine_if.slave  bus
);

  localparam int X_MAX = bound_max(SCREEN_W, OBJECT_W);
  localparam int Y_MAX = bound_max(SCREEN_H, OBJECT_H);
  localparam int CNT_W = (POP_FRAMES < 2) ? 1 : $clog2(POP_FRAMES + 1);

  ball_state_e state_q, state_d;
  int          pos_x_q, pos_x_d;
  int          pos_y_q, pos_y_d;
  int          x_speed_q, x_speed_d;
  int          y_speed_q, y_speed_d;
  logic        spawn_ack_q, spawn_ack_d;

  // Frame-update candidates, computed from registered position/speed.
  int          x_speed_upd, y_speed_upd;
  int          pos_x_upd, pos_y_upd;
  int          spawn_x_spd, spawn_y_spd;

  logic        cnt_load, cnt_en, cnt_done;

  assign cnt_load = (state_q == MOVE) && bus.kill;
  assign cnt_en   = (state_q == POP) && bus.startOfFrame;

  pop_frame_counter #(
    .CNT_W (CNT_W)
  ) u_pop_cnt (
    .clk      (clk),
    .rst_n    (resetN),
    .load     (cnt_load),
    .load_val (CNT_W'(POP_FRAMES)),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  always_comb begin
    // Reflection is decided on the registered position, so a ball that
    // sits exactly on a boundary turns around on its next frame.
    x_speed_upd = x_speed_q;
    if (((pos_x_q <= 0) && (x_speed_q < 0)) ||
        ((pos_x_q >= X_MAX) && (x_speed_q > 0))) begin
      x_speed_upd = -x_speed_q;
    end

    // Gravity is skipped on a bounce frame so the reflected speed is exact.
    if ((pos_y_q >= Y_MAX) && (y_speed_q > 0)) begin
      y_speed_upd = -y_speed_q;
    end else if ((pos_y_q <= 0) && (y_speed_q < 0)) begin
      y_speed_upd = -y_speed_q;
    end else begin
      y_speed_upd = y_speed_q + GRAVITY;
    end

    spawn_x_spd = bus.Xspeed_in;
    spawn_y_spd = bus.Yspeed_in;

`ifdef BALL_SPEED_SAT_EN
    x_speed_upd = sat_speed(x_speed_upd);
    y_speed_upd = sat_speed(y_speed_upd);
    spawn_x_spd = sat_speed(spawn_x_spd);
    spawn_y_spd = sat_speed(spawn_y_spd);
`endif

    pos_x_upd = clamp_pos(pos_x_q + x_speed_upd, X_MAX);
    pos_y_upd = clamp_pos(pos_y_q + y_speed_upd, Y_MAX);
  end

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    x_speed_d   = x_speed_q;
    y_speed_d   = y_speed_q;
    spawn_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        // kill is meaningless without a ball; spawn always wins here.
        if (bus.spawn) begin
          pos_x_d     = bus.spawnX * FIXED_POINT_MULTIPLIER;
          pos_y_d     = bus.spawnY * FIXED_POINT_MULTIPLIER;
          x_speed_d   = spawn_x_spd;
          y_speed_d   = spawn_y_spd;
          spawn_ack_d = 1'b1;
          state_d     = MOVE;
        end
      end
      MOVE: begin
        // kill freezes the ball even on a frame tick.
        if (bus.kill) begin
          state_d = POP;
        end else if (bus.startOfFrame) begin
          x_speed_d = x_speed_upd;
          y_speed_d = y_speed_upd;
          pos_x_d   = pos_x_upd;
          pos_y_d   = pos_y_upd;
        end
      end
      POP: begin
        if (cnt_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      pos_x_q     <= 0;
      pos_y_q     <= 0;
      x_speed_q   <= 0;
      y_speed_q   <= 0;
      spawn_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      x_speed_q   <= x_speed_d;
      y_speed_q   <= y_speed_d;
      spawn_ack_q <= spawn_ack_d;
    end
  end

  // Outputs come straight from flops (or a fixed shift of a flop).
  // Positions are non-negative after clamping, so the shift equals the divide.
  assign bus.spawn_ack  = spawn_ack_q;
  assign bus.active     = (state_q == MOVE);
  assign bus.pop        = (state_q == POP);
  assign bus.topLeftX   = pos_x_q >>> FPM_SHIFT;
  assign bus.topLeftY   = pos_y_q >>> FPM_SHIFT;
  assign bus.Xspeed_out = x_speed_q;
  assign bus.Yspeed_out = y_speed_q;
  assign bus.state_dbg  = state_q;

endmodule
